// File: rtl/ne16_streamer_sequencer.sv
// ---------------------------------------------------------------------------
// ne16_streamer_sequencer
//
// Sequences the NE16 streamer's shared TCDM path between the load sources
// (feat / weight / norm / streamin) and the store sink (conv). One command is
// handled at a time. When the command needs a different path than the one
// currently selected, the sequencer:
//   1. waits for the TCDM FIFO to drain,
//   2. switches the selects and clears the affected side and the FIFO,
//   3. lets the path settle,
//   4. starts the side, and
//   5. waits for that side's done pulse.
// Load and store traffic therefore never share the FIFO.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   enable_i             0 freezes state/counters/selects and masks pulses
//   clear_i              synchronous soft clear, highest priority
//   cmd_valid_i/_ready_o command handshake, cmd_kind_i latched on accept
//   tcdm_fifo_empty_i    FIFO empty flag used to gate select changes
//   source_done_i        load-side transfer-done pulse
//   sink_done_i          store-side transfer-done pulse
//   ld_st_mux_sel_o      0 = load path, 1 = store path
//   ld_which_sel_o       load target 0..3
//   clear_*_o            one-cycle clears of source, sink and FIFO
//   source/sink_start_o  one-cycle start pulses
//   busy_o               FSM not idle
//   done_o               one-cycle completion pulse
//   error_o              sticky error (illegal command or watchdog)
// ---------------------------------------------------------------------------
module ne16_streamer_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_kind_i,
    input  logic       tcdm_fifo_empty_i,
    input  logic       source_done_i,
    input  logic       sink_done_i,
    output logic       ld_st_mux_sel_o,
    output logic [1:0] ld_which_sel_o,
    output logic       clear_source_o,
    output logic       clear_sink_o,
    output logic       clear_fifo_o,
    output logic       source_start_o,
    output logic       sink_start_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_SWITCH = 3'd2,
        S_SETTLE = 3'd3,
        S_START  = 3'd4,
        S_BUSY   = 3'd5
    } state_e;

    localparam logic [2:0] KIND_STORE = 3'd4;

    // SETTLE occupies max(SETTLE_CYCLES,1) cycles: the counter is loaded with
    // one less than the settle length and START follows when it reads zero.
    localparam logic [3:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    localparam logic [CNT_WIDTH-1:0] WDOG_MAX   = '1;
    // TIMEOUT_CYCLES is expected to fit in CNT_WIDTH bits.
    localparam logic [CNT_WIDTH-1:0] WDOG_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                 WDOG_EN    = (TIMEOUT_CYCLES != 0);

    function automatic logic is_illegal(input logic [2:0] kind);
        return (kind > KIND_STORE);
    endfunction

    function automatic logic is_store(input logic [2:0] kind);
        return (kind == KIND_STORE);
    endfunction

    // A store matches whenever the store path is already selected; a load
    // matches only if the load path and the same target are selected.
    function automatic logic sel_match(input logic [2:0] kind,
                                       input logic       ld_st,
                                       input logic [1:0] which);
        if (is_store(kind)) begin
            return ld_st;
        end else begin
            return (!ld_st) && (which == kind[1:0]);
        end
    endfunction

    state_e               state_q, state_d;
    logic [2:0]           kind_q, kind_d;
    logic                 ld_st_q, ld_st_d;
    logic [1:0]           which_q, which_d;
    logic [3:0]           settle_q, settle_d;
    logic [CNT_WIDTH-1:0] wdog_q, wdog_d;
    logic                 error_q, error_d;

    logic                 cmd_ready_s;
    logic                 clear_source_s;
    logic                 clear_sink_s;
    logic                 clear_fifo_s;
    logic                 source_start_s;
    logic                 sink_start_s;
    logic                 done_s;
    logic                 active_done_s;
    logic [CNT_WIDTH-1:0] wdog_inc_s;

    // Handshake ready: idle, enabled, no error; clear_i also blocks accept.
    always_comb begin
        cmd_ready_s = (state_q == S_IDLE) && enable_i && !error_q && !clear_i;
    end

    // Watchdog count including the current BUSY cycle, saturating.
    always_comb begin
        if (wdog_q == WDOG_MAX) begin
            wdog_inc_s = wdog_q;
        end else begin
            wdog_inc_s = wdog_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Done input of the side that is currently running.
    always_comb begin
        if (is_store(kind_q)) begin
            active_done_s = sink_done_i;
        end else begin
            active_done_s = source_done_i;
        end
    end

    // Next-state and pulse generation.
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        ld_st_d        = ld_st_q;
        which_d        = which_q;
        settle_d       = settle_q;
        wdog_d         = wdog_q;
        error_d        = error_q;
        clear_source_s = 1'b0;
        clear_sink_s   = 1'b0;
        clear_fifo_s   = 1'b0;
        source_start_s = 1'b0;
        sink_start_s   = 1'b0;
        done_s         = 1'b0;

        if (clear_i) begin
            state_d  = S_IDLE;
            kind_d   = 3'd0;
            ld_st_d  = 1'b0;
            which_d  = 2'd0;
            settle_d = 4'd0;
            wdog_d   = '0;
            error_d  = 1'b0;
        end else if (!enable_i) begin
            // Everything holds; pulses stay at their zero defaults.
            state_d = state_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_s) begin
                        kind_d = cmd_kind_i;
                        if (is_illegal(cmd_kind_i)) begin
                            error_d = 1'b1;
                        end else if (sel_match(cmd_kind_i, ld_st_q, which_q)) begin
                            state_d = S_START;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (tcdm_fifo_empty_i) begin
                        state_d = S_SWITCH;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_SWITCH: begin
                    ld_st_d = is_store(kind_q);
                    if (is_store(kind_q)) begin
                        which_d        = which_q;
                        clear_sink_s   = 1'b1;
                    end else begin
                        which_d        = kind_q[1:0];
                        clear_source_s = 1'b1;
                    end
                    clear_fifo_s = 1'b1;
                    settle_d     = SETTLE_LOAD;
                    state_d      = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == 4'd0) begin
                        state_d = S_START;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                S_START: begin
                    if (is_store(kind_q)) begin
                        sink_start_s   = 1'b1;
                    end else begin
                        source_start_s = 1'b1;
                    end
                    wdog_d  = '0;
                    state_d = S_BUSY;
                end
                S_BUSY: begin
                    wdog_d = wdog_inc_s;
                    // A done in the same cycle as the watchdog limit wins.
                    if (active_done_s) begin
                        done_s  = 1'b1;
                        state_d = S_IDLE;
                    end else if (WDOG_EN && (wdog_inc_s >= WDOG_LIMIT)) begin
                        error_d        = 1'b1;
                        clear_source_s = 1'b1;
                        clear_sink_s   = 1'b1;
                        clear_fifo_s   = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, select, counter and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            kind_q   <= 3'd0;
            ld_st_q  <= 1'b0;
            which_q  <= 2'd0;
            settle_q <= 4'd0;
            wdog_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            ld_st_q  <= ld_st_d;
            which_q  <= which_d;
            settle_q <= settle_d;
            wdog_q   <= wdog_d;
            error_q  <= error_d;
        end
    end

    assign cmd_ready_o     = cmd_ready_s;
    assign ld_st_mux_sel_o = ld_st_q;
    assign ld_which_sel_o  = which_q;
    assign clear_source_o  = clear_source_s;
    assign clear_sink_o    = clear_sink_s;
    assign clear_fifo_o    = clear_fifo_s;
    assign source_start_o  = source_start_s;
    assign sink_start_o    = sink_start_s;
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_s;
    assign error_o         = error_q;

endmodule
